// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequential radix-2 Booth controller for signed WIDTHxWIDTH
// multiplication. Holds the A/Q/Q_1 working registers and borrows the shared
// external (WIDTH+1)-bit adder, once to form -M and then once per iteration.
//
// Optional build macro BOOTH_SKIP_EN: when defined, iterations whose Booth pair
// is 00 or 11 shift inside the EVAL cycle instead of spending a SHIFT cycle,
// so latency becomes 10 + (number of add/subtract iterations).
// Without it every operation takes a fixed 18 cycles from start to done.
module booth_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH:0]       add_a,
   output logic [WIDTH:0]       add_b,
   input  logic [WIDTH+1:0]     add_sum
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      NEG,
      EVAL,
      SHIFT,
      DONE
   } state_t;

   state_t             state;
   state_t             next_state;

   logic [WIDTH:0]     a;
   logic [WIDTH-1:0]   q;
   logic               q_1;
   logic [WIDTH:0]     m;
   logic [WIDTH:0]     negm;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] product_r;
   logic               last_iter;
   logic               sum_unused;

   // The adder's top bit only mirrors bit WIDTH; it carries no extra information.
   assign sum_unused = add_sum[WIDTH+1];

   assign last_iter = (count == CW'(WIDTH - 1));
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // During the done cycle the freshly finished result is shown directly so the
   // requester sees a valid product alongside the done pulse; afterwards the
   // registered copy holds it until the next accepted start.
   assign product   = (state == DONE) ? {a[WIDTH-1:0], q} : product_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection and adder operand steering.
   always_comb begin
      next_state = state;
      add_a      = '0;
      add_b      = '0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = NEG;
            end
         end
         NEG: begin
            add_a      = ~m;
            add_b      = {{WIDTH{1'b0}}, 1'b1};
            next_state = EVAL;
         end
         EVAL: begin
            add_a = a;
            case ({q[0], q_1})
               2'b01:   add_b = m;
               2'b10:   add_b = negm;
               default: add_b = '0;
            endcase
`ifdef BOOTH_SKIP_EN
            if (q[0] == q_1) begin
               next_state = last_iter ? DONE : EVAL;
            end else begin
               next_state = SHIFT;
            end
`else
            next_state = SHIFT;
`endif
         end
         SHIFT: begin
            next_state = last_iter ? DONE : EVAL;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand capture, -M formation, Booth add/subtract and arithmetic shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a         <= '0;
         q         <= '0;
         q_1       <= 1'b0;
         m         <= '0;
         negm      <= '0;
         count     <= '0;
         product_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m     <= {multiplicand[WIDTH-1], multiplicand};
                  q     <= multiplier;
                  a     <= '0;
                  q_1   <= 1'b0;
                  count <= '0;
               end
            end
            NEG: begin
               negm <= add_sum[WIDTH:0];
            end
            EVAL: begin
               if (q[0] != q_1) begin
                  a <= add_sum[WIDTH:0];
               end
`ifdef BOOTH_SKIP_EN
               else begin
                  {a, q, q_1} <= {a[WIDTH], a, q};
                  count       <= count + 1'b1;
               end
`endif
            end
            SHIFT: begin
               {a, q, q_1} <= {a[WIDTH], a, q};
               count       <= count + 1'b1;
            end
            DONE: begin
               product_r <= {a[WIDTH-1:0], q};
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Testbench for booth_mult_ctrl. Models the shared 9-bit adder, keeps a
// scoreboard of expected products/latencies and checks each scenario in turn.
// Latency expectations follow BOOTH_SKIP_EN when the bench is built with it.
module tb_booth_mult_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [8:0]  add_a;
   logic [8:0]  add_b;
   logic [9:0]  add_sum;
   logic [8:0]  sum9;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];
   int          lat_q[$];

   booth_mult_ctrl #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_sum      (add_sum)
   );

   // External adder: 9-bit sum with bit 9 copying bit 8.
   assign sum9    = add_a + add_b;
   assign add_sum = {sum9[8], sum9};

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected start-to-done latency for a given multiplier.
   function automatic int exp_latency(input logic [7:0] mp);
      int   k;
      logic prev;
      k    = 0;
      prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (mp[i] != prev) k++;
         prev = mp[i];
      end
`ifdef BOOTH_SKIP_EN
      return 10 + k;
`else
      return (k >= 0) ? 18 : 18;
`endif
   endfunction

   // Drives one start pulse and records expectations; returns at the falling
   // edge of cycle 1 (the accepting edge is cycle 0).
   task automatic applyStimulus(input logic signed [7:0] mc, input logic signed [7:0] mp);
      int p;
      @(negedge clk);
      multiplicand = mc;
      multiplier   = mp;
      start        = 1'b1;
      p = int'(mc) * int'(mp);
      exp_q.push_back(p[15:0]);
      lat_q.push_back(exp_latency(mp));
      @(negedge clk);
      start        = 1'b0;
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
   endtask

   // Waits (bounded) for done starting at cycle cyc0; reports cycle, busy count and product.
   task automatic wait_done(input int cyc0, output int lat, output int busy_cnt, output logic [15:0] prod);
      int cyc;
      cyc      = cyc0;
      lat      = -1;
      busy_cnt = 0;
      prod     = 'x;
      while (cyc < 200) begin
         if (busy) busy_cnt++;
         if (done) begin
            lat  = cyc;
            prod = product;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (product !== 16'h0000) begin errors++; $display("[TB] FAIL reset_product: got %h expected 0000", product); end
      checks++; if ({add_a, add_b} !== 18'h0) begin errors++; $display("[TB] FAIL reset_adder_ops: got %h/%h expected 000/000", add_a, add_b); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      int lat, bc, el;
      logic [15:0] prod, ex;
      applyStimulus(8'sd3, 8'sd5);
      wait_done(1, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (prod !== ex) begin errors++; $display("[TB] FAIL basic_product: got %h expected %h", prod, ex); end
      checks++; if (ex !== 16'h000F) begin errors++; $display("[TB] FAIL basic_model: got %h expected 000f", ex); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, el); end
      checks++; if (bc !== el) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", bc, el); end
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL basic_after_done: got busy/done %b expected 00", {busy, done}); end
      checks++; if (product !== 16'h000F) begin errors++; $display("[TB] FAIL basic_hold: got %h expected 000f", product); end
   endtask

   task automatic test_negm();
      int lat, bc, el;
      logic [15:0] prod, ex;
      applyStimulus(8'sh80, 8'sh80);
      checks++; if (add_a !== 9'h07F || add_b !== 9'h001) begin errors++; $display("[TB] FAIL neg_operands: got %h/%h expected 07f/001", add_a, add_b); end
      wait_done(1, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (dut.negm !== 9'h080) begin errors++; $display("[TB] FAIL negm_value: got %h expected 080", dut.negm); end
      checks++; if (prod !== ex || prod !== 16'h4000) begin errors++; $display("[TB] FAIL min_product: got %h expected %h", prod, ex); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL min_latency: got %0d expected %0d", lat, el); end
   endtask

   task automatic test_signs();
      int lat, bc, el;
      logic [15:0] prod, ex;
      applyStimulus(-8'sd7, 8'sd6);
      wait_done(1, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (prod !== ex || prod !== 16'hFFD6) begin errors++; $display("[TB] FAIL neg_pos_product: got %h expected %h", prod, ex); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL neg_pos_latency: got %0d expected %0d", lat, el); end
      applyStimulus(8'sd0, -8'sd1);
      wait_done(1, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (prod !== ex || prod !== 16'h0000) begin errors++; $display("[TB] FAIL zero_product: got %h expected %h", prod, ex); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected %0d", lat, el); end
   endtask

   task automatic test_start_while_busy();
      int lat, bc, el, extra;
      logic [15:0] prod, ex;
      applyStimulus(8'sd100, -8'sd3);
      repeat (4) @(negedge clk);
      multiplicand = 8'd7;
      multiplier   = 8'd7;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (prod !== ex || prod !== 16'hFED4) begin errors++; $display("[TB] FAIL busy_start_product: got %h expected %h", prod, ex); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", lat, el); end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) extra++;
      end
      checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL busy_start_extra_done: got %0d expected 0", extra); end
      checks++; if (product !== 16'hFED4) begin errors++; $display("[TB] FAIL busy_start_hold: got %h expected fed4", product); end
   endtask

   task automatic test_reset_mid();
      int lat, bc, el;
      logic [15:0] prod, ex;
      applyStimulus(8'sd50, 8'sd50);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
      checks++; if (product !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_product: got %h expected 0000", product); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'sd12, -8'sd11);
      wait_done(1, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (prod !== ex || prod !== 16'hFF7C) begin errors++; $display("[TB] FAIL after_reset_product: got %h expected %h", prod, ex); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL after_reset_latency: got %0d expected %0d", lat, el); end
   endtask

   task automatic test_skip_cases();
      int lat, bc, el;
      logic [15:0] prod, ex;
      applyStimulus(8'sd5, 8'sd0);
      wait_done(1, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (prod !== ex) begin errors++; $display("[TB] FAIL skip_zero_product: got %h expected %h", prod, ex); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL skip_zero_latency: got %0d expected %0d", lat, el); end
      applyStimulus(8'sd5, 8'sd85);
      wait_done(1, lat, bc, prod);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (prod !== ex || prod !== 16'h01A9) begin errors++; $display("[TB] FAIL skip_alt_product: got %h expected %h", prod, ex); end
      checks++; if (lat !== el || lat !== 18) begin errors++; $display("[TB] FAIL skip_alt_latency: got %0d expected %0d", lat, el); end
   endtask

   task automatic test_back_to_back();
      int lat, bc, el;
      logic [15:0] prod, ex;
      logic signed [7:0] mcs[4];
      logic signed [7:0] mps[4];
      mcs[0] = 8'sd127; mps[0] = 8'sh80;
      mcs[1] = 8'sh80;  mps[1] = 8'sd127;
      for (int i = 2; i < 4; i++) begin
         mcs[i] = 8'($urandom);
         mps[i] = 8'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mcs[i], mps[i]);
         wait_done(1, lat, bc, prod);
         ex = exp_q.pop_front(); el = lat_q.pop_front();
         checks++; if (prod !== ex) begin errors++; $display("[TB] FAIL b2b_product[%0d]: got %h expected %h", i, prod, ex); end
         checks++; if (lat !== el) begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, el); end
      end
   endtask

   // Runs every scenario in sequence and prints the summary.
   initial begin
      test_reset();
      test_basic();
      test_negm();
      test_signs();
      test_start_while_busy();
      test_reset_mid();
      test_skip_cases();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
